// File: rtl/joypad_scanner_if.sv
// CPU-side bus bundle for the joypad scanner.
//   ph2_falling  : CPU cycle enable, qualifies every access
//   cpu_addr     : CPU address
//   cpu_rnw      : 1 = read, 0 = write
//   cpu_data_in  : write data bit 0 (strobe)
//   cpu_data_out : read data onto the OR-bus, 8'h00 when not addressed
interface joypad_scanner_if;
  logic        ph2_falling;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic        cpu_data_in;
  logic [7:0]  cpu_data_out;

  modport master (
    output ph2_falling, cpu_addr, cpu_rnw, cpu_data_in,
    input  cpu_data_out
  );

  modport slave (
    input  ph2_falling, cpu_addr, cpu_rnw, cpu_data_in,
    output cpu_data_out
  );
endinterface

// File: rtl/joypad_scanner.sv
// Autonomous serial-joypad scan engine. Shifts 1-4 NES/SNES pads into
// committed snapshots and serves them bit-serially at BASE_ADDR/BASE_ADDR+1.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   bus        : CPU bus (slave side), strobe write and port reads
//   frame_tick : vblank pulse, starts a scan when AUTO_POLL=1
//   pad_data   : serial pad data, active-low
//   pad_clk    : pad shift clocks, idle high
//   pad_latch  : parallel-load strobe to all pads
//   scan_busy  : scan FSM not idle
//   pad_state  : committed snapshots, port 0 in LSBs, 1 = pressed
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for a request
// S_LATCH  | pad_latch high for 2H cycles
// S_SETTLE | latch low for H cycles, sample bit 0 at the end
// S_CLK_LO | pad_clk low for H cycles
// S_CLK_HI | pad_clk high for H cycles, sample next bit at end
// S_COMMIT | copy shift registers into the snapshots
module joypad_scanner #(
  parameter int          NUM_PORTS   = 2,
  parameter int          PAD_BITS    = 8,
  parameter int          HALF_PERIOD = 150,
  parameter logic [15:0] BASE_ADDR   = 16'h4016,
  parameter bit          AUTO_POLL   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  joypad_scanner_if.slave               bus,
  input  logic                          frame_tick,
  input  logic [NUM_PORTS-1:0]          pad_data,
  output logic [NUM_PORTS-1:0]          pad_clk,
  output logic                          pad_latch,
  output logic                          scan_busy,
  output logic [NUM_PORTS*PAD_BITS-1:0] pad_state
);

  localparam int HW = $clog2(2 * HALF_PERIOD);
  localparam int BW = $clog2(PAD_BITS + 1);
  localparam logic [HW-1:0] LOAD_2H  = HW'(2 * HALF_PERIOD - 1);
  localparam logic [HW-1:0] LOAD_H   = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAD_BITS - 1);
  localparam logic [BW-1:0] BITS_MAX = BW'(PAD_BITS);
  localparam logic [15:0]   ADDR1    = BASE_ADDR + 16'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_CLK_LO, S_CLK_HI, S_COMMIT
  } state_t;

  state_t                                 state_q, state_d;
  logic [HW-1:0]                          hp_cnt_q, hp_cnt_d;
  logic [BW-1:0]                          bit_cnt_q, bit_cnt_d;
  logic                                   strobe_q, strobe_d;
  logic                                   pending_q, pending_d;
  logic [NUM_PORTS-1:0][PAD_BITS-1:0]     shift_q, shift_d;
  logic [NUM_PORTS-1:0][PAD_BITS-1:0]     snap_q, snap_d;
  logic [NUM_PORTS-1:0][BW-1:0]           ptr_q, ptr_d;
  logic                                   pad_latch_q, pad_latch_d;
  logic [NUM_PORTS-1:0]                   pad_clk_q, pad_clk_d;
  logic                                   scan_busy_q, scan_busy_d;

  logic                 addr0, addr1;
  logic                 wr_strobe, strobe_fall, req;
  logic                 rd_inc0, rd_inc1;
  logic                 sample;
  logic [NUM_PORTS-1:0] pad_inv;
  logic [7:0]           data_out;

  assign addr0       = (bus.cpu_addr == BASE_ADDR);
  assign addr1       = (bus.cpu_addr == ADDR1);
  assign wr_strobe   = bus.ph2_falling && !bus.cpu_rnw && addr0;
  assign strobe_fall = wr_strobe && strobe_q && !bus.cpu_data_in;
  assign req         = strobe_fall || (AUTO_POLL && frame_tick);
  assign rd_inc0     = bus.ph2_falling && bus.cpu_rnw && addr0 && !strobe_q;
  assign rd_inc1     = bus.ph2_falling && bus.cpu_rnw && addr1 && !strobe_q;
  assign pad_inv     = ~pad_data;

  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = strobe_q;
    pending_d = pending_q || req;
    shift_d   = shift_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    sample    = 1'b0;

    if (wr_strobe) strobe_d = bus.cpu_data_in;

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (strobe_d || strobe_q) begin
        ptr_d[p] = '0;
      end else if (((p % 2 == 0) ? rd_inc0 : rd_inc1) && (ptr_q[p] != BITS_MAX)) begin
        ptr_d[p] = ptr_q[p] + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_d) begin
          pending_d = 1'b0;
          hp_cnt_d  = LOAD_2H;
          state_d   = S_LATCH;
        end
      end
      S_LATCH: begin
        if (hp_cnt_q == '0) begin
          hp_cnt_d = LOAD_H;
          state_d  = S_SETTLE;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (hp_cnt_q == '0) begin
          sample    = 1'b1;
          bit_cnt_d = BW'(1);
          hp_cnt_d  = LOAD_H;
          state_d   = (PAD_BITS == 1) ? S_COMMIT : S_CLK_LO;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_CLK_LO: begin
        if (hp_cnt_q == '0) begin
          hp_cnt_d = LOAD_H;
          state_d  = S_CLK_HI;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_CLK_HI: begin
        if (hp_cnt_q == '0) begin
          sample    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          hp_cnt_d  = LOAD_H;
          state_d   = (bit_cnt_q == LAST_BIT) ? S_COMMIT : S_CLK_LO;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_COMMIT: begin
        snap_d  = shift_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shift in at the MSB: after PAD_BITS samples the first one sits in bit 0.
    if (sample) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        shift_d[p] = (shift_q[p] >> 1) | (PAD_BITS'(pad_inv[p]) << (PAD_BITS - 1));
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign pad_latch_d = (state_d == S_LATCH);
  assign scan_busy_d = (state_d != S_IDLE);
  assign pad_clk_d   = (state_d == S_CLK_LO) ? '0 : '1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      hp_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      strobe_q    <= 1'b0;
      pending_q   <= 1'b0;
      shift_q     <= '0;
      snap_q      <= '0;
      ptr_q       <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= '1;
      scan_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_cnt_q    <= hp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      strobe_q    <= strobe_d;
      pending_q   <= pending_d;
      shift_q     <= shift_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      scan_busy_q <= scan_busy_d;
    end
  end

  // Port p answers at BASE_ADDR+(p%2) on data bit p/2; exhausted pointers read 1.
  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.cpu_rnw && ((p % 2 == 0) ? addr0 : addr1)) begin
        data_out[p/2] = (ptr_q[p] < BITS_MAX) ?
                        |(snap_q[p] & (PAD_BITS'(1) << ptr_q[p])) : 1'b1;
      end
    end
  end

  assign bus.cpu_data_out = data_out;
  assign pad_latch        = pad_latch_q;
  assign pad_clk          = pad_clk_q;
  assign scan_busy        = scan_busy_q;
  assign pad_state        = snap_q;

endmodule

// File: tb/tb_joypad_scanner.sv
module tb_joypad_scanner;
  localparam int NP = 4;
  localparam int PB = 8;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            frame_tick = 1'b0;
  logic [NP-1:0]   pad_data;
  logic [NP-1:0]   pad_clk;
  logic            pad_latch;
  logic            scan_busy;
  logic [NP*PB-1:0] pad_state;

  joypad_scanner_if bus ();

  joypad_scanner #(
    .NUM_PORTS(NP), .PAD_BITS(PB), .HALF_PERIOD(H),
    .BASE_ADDR(16'h4016), .AUTO_POLL(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .frame_tick(frame_tick),
    .pad_data(pad_data), .pad_clk(pad_clk), .pad_latch(pad_latch),
    .scan_busy(scan_busy), .pad_state(pad_state)
  );

  always #5 clk = ~clk;

  // Pad model: 4021-style shift register, 1 = pressed internally, pin active-low.
  logic [PB-1:0] pad_val [NP];
  logic [PB-1:0] pad_sr  [NP];
  logic [NP-1:0] clk_prev;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!rstn) pad_sr[p] <= '0;
      else if (pad_latch) pad_sr[p] <= pad_val[p];
      else if (pad_clk[p] && !clk_prev[p]) pad_sr[p] <= pad_sr[p] >> 1;
    end
    clk_prev <= pad_clk;
  end

  always_comb begin
    pad_data = '1;
    for (int p = 0; p < NP; p++) pad_data[p] = ~pad_sr[p][0];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [NP*PB-1:0] snap_exp_q [$];
  logic [7:0]       rd_exp_q   [$];
  logic [PB-1:0]    snap_m [NP];
  int               mptr   [NP];
  logic             m_strobe;

  function automatic logic [NP*PB-1:0] pack_vals();
    logic [NP*PB-1:0] r;
    for (int p = 0; p < NP; p++) r[p*PB +: PB] = pad_val[p];
    return r;
  endfunction

  function automatic void set_snap(input logic [NP*PB-1:0] v);
    for (int p = 0; p < NP; p++) snap_m[p] = v[p*PB +: PB];
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [7:0] b;
    int k;
    b = 8'h00;
    if (a == 16'h4016 || a == 16'h4017) begin
      k = (a == 16'h4017) ? 1 : 0;
      for (int p = 0; p < NP; p++)
        if (p % 2 == k) b[p/2] = (mptr[p] < PB) ? snap_m[p][mptr[p]] : 1'b1;
    end
    return b;
  endfunction

  function automatic void model_advance(input logic [15:0] a);
    int k;
    if (!m_strobe && (a == 16'h4016 || a == 16'h4017)) begin
      k = (a == 16'h4017) ? 1 : 0;
      for (int p = 0; p < NP; p++)
        if (p % 2 == k && mptr[p] < PB) mptr[p]++;
    end
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      snap_m[p] = '0;
      mptr[p]   = 0;
    end
    m_strobe = 1'b0;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic d);
    @(posedge clk); #1;
    bus.ph2_falling = 1'b1; bus.cpu_addr = a; bus.cpu_rnw = 1'b0; bus.cpu_data_in = d;
    @(posedge clk); #1;
    bus.ph2_falling = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_rnw = 1'b1; bus.cpu_data_in = 1'b0;
    if (a == 16'h4016) begin
      if (d || m_strobe) for (int p = 0; p < NP; p++) mptr[p] = 0;
      m_strobe = d;
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] got);
    @(posedge clk); #1;
    bus.ph2_falling = 1'b1; bus.cpu_addr = a; bus.cpu_rnw = 1'b1;
    #1 got = bus.cpu_data_out;
    @(posedge clk); #1;
    bus.ph2_falling = 1'b0; bus.cpu_addr = 16'h0000;
  endtask

  task automatic frame_pulse();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_busy_fall(input int budget, output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b1;
    while (cyc < budget) begin
      if (scan_busy === 1'b0) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b expected 0", pad_latch); end
    n_checks++; if (pad_clk !== 4'hF) begin n_fail++; $display("FAIL reset_pad_clk: got %h expected f", pad_clk); end
    n_checks++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", scan_busy); end
    n_checks++; if (pad_state !== '0) begin n_fail++; $display("FAIL reset_pad_state: got %h expected 0", pad_state); end
    rstn = 1'b1;
    rd_exp_q.push_back(model_read(16'h4016));
    model_advance(16'h4016);
    bus_read(16'h4016, got);
    exp = rd_exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL reset_read: got %h expected %h", got, exp); end
  endtask

  task automatic test_scan();
    int t, latch_cnt, pulses, commit_t, fall_t;
    logic prev_clk;
    logic [NP*PB-1:0] prev_state, exp;
    pad_val[0] = 8'hA5; pad_val[1] = 8'h3D; pad_val[2] = 8'h01; pad_val[3] = 8'h0F;
    bus_write(16'h4016, 1'b1);
    snap_exp_q.push_back(pack_vals());
    bus_write(16'h4016, 1'b0);
    n_checks++; if (pad_latch !== 1'b1) begin n_fail++; $display("FAIL scan_latch_latency: got %b expected 1", pad_latch); end
    n_checks++; if (scan_busy !== 1'b1) begin n_fail++; $display("FAIL scan_busy_rise: got %b expected 1", scan_busy); end
    t = 0; latch_cnt = 0; pulses = 0; commit_t = -1; fall_t = -1;
    prev_clk = 1'b1; prev_state = pad_state;
    while (t < 200) begin
      if (pad_latch === 1'b1) latch_cnt++;
      if (prev_clk === 1'b1 && pad_clk[0] === 1'b0) pulses++;
      prev_clk = pad_clk[0];
      if (commit_t < 0 && pad_state !== prev_state) commit_t = t;
      if (fall_t < 0 && scan_busy === 1'b0) fall_t = t;
      if (commit_t >= 0 && fall_t >= 0) break;
      @(posedge clk); #1;
      t++;
    end
    n_checks++; if (latch_cnt != 2*H) begin n_fail++; $display("FAIL scan_latch_width: got %0d expected %0d", latch_cnt, 2*H); end
    n_checks++; if (pulses != PB-1) begin n_fail++; $display("FAIL scan_clk_pulses: got %0d expected %0d", pulses, PB-1); end
    n_checks++; if (commit_t != 3*H + 2*H*(PB-1) + 1) begin n_fail++; $display("FAIL scan_commit_latency: got %0d expected %0d", commit_t, 3*H + 2*H*(PB-1) + 1); end
    n_checks++; if (fall_t != commit_t) begin n_fail++; $display("FAIL scan_busy_fall: got %0d expected %0d", fall_t, commit_t); end
    exp = snap_exp_q.pop_front();
    n_checks++; if (pad_state !== exp) begin n_fail++; $display("FAIL scan_pad_state: got %h expected %h", pad_state, exp); end
    set_snap(exp);
  endtask

  task automatic test_read_seq();
    logic [7:0] got, exp;
    logic [NP*PB-1:0] sexp;
    int cyc;
    bit to;
    pad_val[0] = 8'h5A;
    bus_write(16'h4016, 1'b1);
    snap_exp_q.push_back(pack_vals());
    bus_write(16'h4016, 1'b0);
    // The new scan is in flight; reads must still come from the old snapshot.
    for (int i = 0; i < 10; i++) begin
      rd_exp_q.push_back(model_read(16'h4016));
      model_advance(16'h4016);
      bus_read(16'h4016, got);
      exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL read4016_%0d: got %h expected %h", i, got, exp); end
    end
    for (int i = 0; i < 2; i++) begin
      rd_exp_q.push_back(model_read(16'h4017));
      model_advance(16'h4017);
      bus_read(16'h4017, got);
      exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL read4017_%0d: got %h expected %h", i, got, exp); end
    end
    wait_busy_fall(200, cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL read_seq_scan_timeout: got busy expected idle"); end
    sexp = snap_exp_q.pop_front();
    n_checks++; if (pad_state !== sexp) begin n_fail++; $display("FAIL read_seq_pad_state: got %h expected %h", pad_state, sexp); end
    set_snap(sexp);
  endtask

  task automatic test_strobe_hold();
    logic [7:0] got, exp;
    logic [NP*PB-1:0] sexp;
    int cyc;
    bit to;
    bus_write(16'h4016, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rd_exp_q.push_back(model_read(16'h4016));
      model_advance(16'h4016);
      bus_read(16'h4016, got);
      exp = rd_exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL hold_read_%0d: got %h expected %h", i, got, exp); end
    end
    rd_exp_q.push_back(model_read(16'h5000));
    bus_read(16'h5000, got);
    exp = rd_exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL read_5000: got %h expected %h", got, exp); end
    // Rescan with pad 0 bit 0 pressed so both data bits of $4016 light up.
    pad_val[0] = 8'hA5;
    snap_exp_q.push_back(pack_vals());
    bus_write(16'h4016, 1'b0);
    wait_busy_fall(200, cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL hold_scan_timeout: got busy expected idle"); end
    sexp = snap_exp_q.pop_front();
    n_checks++; if (pad_state !== sexp) begin n_fail++; $display("FAIL hold_pad_state: got %h expected %h", pad_state, sexp); end
    set_snap(sexp);
    bus_write(16'h4016, 1'b1);
    rd_exp_q.push_back(model_read(16'h4016));
    model_advance(16'h4016);
    bus_read(16'h4016, got);
    exp = rd_exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL four_port_read: got %h expected %h", got, exp); end
    rd_exp_q.push_back(model_read(16'h4017));
    model_advance(16'h4017);
    bus_read(16'h4017, got);
    exp = rd_exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL four_port_read4017: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [NP*PB-1:0] sexp;
    int cyc, extra;
    bit to;
    pad_val[0] = 8'hC3; pad_val[1] = 8'h81; pad_val[2] = 8'h7E; pad_val[3] = 8'h18;
    snap_exp_q.push_back(pack_vals());
    frame_pulse();
    n_checks++; if (pad_latch !== 1'b1) begin n_fail++; $display("FAIL tick_latch_latency: got %b expected 1", pad_latch); end
    repeat (12) @(posedge clk);
    #1;
    pad_val[0] = 8'h96; pad_val[1] = 8'h42; pad_val[2] = 8'hE7; pad_val[3] = 8'h5B;
    snap_exp_q.push_back(pack_vals());
    frame_pulse();
    repeat (5) @(posedge clk);
    frame_pulse();
    wait_busy_fall(200, cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout: got busy expected idle"); end
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_latch: got %b expected 0", pad_latch); end
    sexp = snap_exp_q.pop_front();
    n_checks++; if (pad_state !== sexp) begin n_fail++; $display("FAIL b2b_first_state: got %h expected %h", pad_state, sexp); end
    @(posedge clk); #1;
    n_checks++; if (pad_latch !== 1'b1 || scan_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got latch %b busy %b expected 1 1", pad_latch, scan_busy); end
    @(posedge clk); #1;
    wait_busy_fall(200, cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout: got busy expected idle"); end
    sexp = snap_exp_q.pop_front();
    n_checks++; if (pad_state !== sexp) begin n_fail++; $display("FAIL b2b_second_state: got %h expected %h", pad_state, sexp); end
    set_snap(sexp);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pad_latch !== 1'b0) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra_scan: got %0d latch cycles expected 0", extra); end
  endtask

  task automatic test_reset_midscan();
    int cyc;
    bit found;
    frame_pulse();
    cyc = 0;
    found = 1'b0;
    while (cyc < 100) begin
      if (pad_clk[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midscan_clk_lo: got no low pad_clk expected one"); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (pad_clk !== 4'hF) begin n_fail++; $display("FAIL midscan_pad_clk: got %h expected f", pad_clk); end
    n_checks++; if (pad_latch !== 1'b0 || scan_busy !== 1'b0) begin n_fail++; $display("FAIL midscan_ctrl: got latch %b busy %b expected 0 0", pad_latch, scan_busy); end
    n_checks++; if (pad_state !== '0) begin n_fail++; $display("FAIL midscan_pad_state: got %h expected 0", pad_state); end
    model_reset();
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  initial begin
    bus.ph2_falling = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_rnw     = 1'b1;
    bus.cpu_data_in = 1'b0;
    for (int p = 0; p < NP; p++) pad_val[p] = '0;
    model_reset();
    test_reset();
    test_scan();
    test_read_seq();
    test_strobe_hold();
    test_back_to_back();
    test_reset_midscan();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
